alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_core.sv | 72 +++++++
 rtl/alu_seq.sv | 130 +++++++++++++
 tb/tb_alu_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state enums and flag bit positions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_INC = 4'd3,
    OP_DEC = 4'd4,
    OP_NOT = 4'd5,
    OP_SUB = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } alu_state_e;

  localparam int FLAG_NEG   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/alu_core.sv
// Single-cycle result/flag evaluation for every non-shift opcode.
// Shift and illegal opcodes produce a zero result with all flags clear.
module alu_core
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         flag_i,
  input  logic [3:0]   op_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   flags_o
);

  logic [N:0]   wide;
  logic [N-1:0] opnd;
  logic [N-1:0] res;
  logic         carry;
  logic         ovf;
  logic         legal;

  always_comb begin
    wide  = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    legal = 1'b1;
    opnd  = flag_i ? b_i : a_i;
    case (alu_op_e'(op_i))
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_NOT: res = ~opnd;
      OP_ADD: begin
        wide  = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, flag_i};
        res   = wide[N-1:0];
        carry = wide[N];
        ovf   = (a_i[N-1] == b_i[N-1]) && (res[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        // The top bit of the N+1 wide difference is the borrow out.
        wide  = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, flag_i};
        res   = wide[N-1:0];
        carry = wide[N];
        ovf   = (a_i[N-1] != b_i[N-1]) && (res[N-1] != a_i[N-1]);
      end
      OP_INC: begin
        wide  = {1'b0, opnd} + (N+1)'(1);
        res   = wide[N-1:0];
        carry = wide[N];
        ovf   = ~opnd[N-1] & res[N-1];
      end
      OP_DEC: begin
        wide  = {1'b0, opnd} - (N+1)'(1);
        res   = wide[N-1:0];
        carry = wide[N];
        ovf   = opnd[N-1] & ~res[N-1];
      end
      default: legal = 1'b0;
    endcase
    result_o = res;
    flags_o  = '0;
    if (legal) begin
      flags_o[FLAG_NEG]   = res[N-1];
      flags_o[FLAG_ZERO]  = (res == '0);
      flags_o[FLAG_CARRY] = carry;
      flags_o[FLAG_OVF]   = ovf;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: one-cycle ops via alu_core, bit-serial shifts via the
// IDLE/SHIFT/DONE FSM. in_valid/in_ready accept a request only when both are
// high; out_valid holds result and flags stable until out_ready is seen.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] ALUA,
  input  logic [N-1:0] ALUB,
  input  logic         ALUFlagIn,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALUResult,
  output logic [3:0]   ALUFlags,
  output logic [1:0]   dbg_state_o
);

  localparam int CNT_W = $clog2(N + 1);

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     work_q, work_d;
  logic             fill_q, fill_d;
  logic             shl_q, shl_d;
  logic [N-1:0]     result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [N-1:0] core_result;
  logic [3:0]   core_flags;
  logic [N-1:0] shifted;
  logic         shift_out;
  logic         is_shift;

  alu_core #(.N(N)) u_core (
    .a_i      (ALUA),
    .b_i      (ALUB),
    .flag_i   (ALUFlagIn),
    .op_i     (ALUControl),
    .result_o (core_result),
    .flags_o  (core_flags)
  );

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign ALUResult   = result_q;
  assign ALUFlags    = flags_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    fill_d    = fill_q;
    shl_d     = shl_q;
    result_d  = result_q;
    flags_d   = flags_q;
    is_shift  = (ALUControl == OP_SHL) || (ALUControl == OP_SHR);
    shift_out = shl_q ? work_q[N-1] : work_q[0];
    shifted   = shl_q ? {work_q[N-2:0], fill_q} : {fill_q, work_q[N-1:1]};
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift) begin
            shl_d  = (ALUControl == OP_SHL);
            fill_d = ALUFlagIn;
            work_d = ALUA;
            // Amounts beyond N behave like N: every original bit is gone.
            cnt_d  = ({1'b0, ALUB} > (N+1)'(N)) ? CNT_W'(N) : CNT_W'(ALUB);
            if (cnt_d == '0) begin
              result_d = ALUA;
              flags_d  = '0;
              flags_d[FLAG_NEG]  = ALUA[N-1];
              flags_d[FLAG_ZERO] = (ALUA == '0);
              state_d  = S_DONE;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            result_d = core_result;
            flags_d  = core_flags;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = shifted;
          flags_d  = '0;
          flags_d[FLAG_NEG]   = shifted[N-1];
          flags_d[FLAG_ZERO]  = (shifted == '0);
          flags_d[FLAG_CARRY] = shift_out;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      fill_q   <= 1'b0;
      shl_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      fill_q   <= fill_d;
      shl_q    <= shl_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (N=4): directed cases plus randomized ops against an
// integer-arithmetic reference model, including latency and hold behaviour.
module tb_alu_seq;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         flag_in;
  logic [3:0]   alu_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  int last_res;
  int last_flg;

  alu_seq #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUA        (alu_a),
    .ALUB        (alu_b),
    .ALUFlagIn   (flag_in),
    .ALUControl  (alu_ctrl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUResult   (alu_result),
    .ALUFlags    (alu_flags),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= (1 << (N - 1))) ? v - (1 << N) : v;
  endfunction

  // Reference model: plain integer arithmetic on the opcode definitions.
  task automatic model(input int op, input int a, input int b, input int f,
                       output int res, output int flg, output int lat);
    int mask, x, s, sv, c, v, cnt, hi, lo;
    mask = (1 << N) - 1;
    hi = (1 << (N - 1)) - 1;
    lo = -(1 << (N - 1));
    x = f ? b : a;
    c = 0; v = 0; res = 0; lat = 1; sv = 0;
    case (op)
      0: res = a & b;
      1: res = a | b;
      2: begin s = a + b + f; res = s & mask; c = int'(s > mask); sv = sgn(a) + sgn(b) + f; end
      3: begin s = x + 1; res = s & mask; c = int'(s > mask); sv = sgn(x) + 1; end
      4: begin res = (x - 1) & mask; c = int'(x == 0); sv = sgn(x) - 1; end
      5: res = ~x & mask;
      6: begin res = (a - b - f) & mask; c = int'(a < b + f); sv = sgn(a) - sgn(b) - f; end
      7: res = a ^ b;
      8, 9: begin
        cnt = (b > N) ? N : b;
        lat = 1 + cnt;
        if (op == 8) begin
          res = ((a << cnt) & mask) | (f ? ((1 << cnt) - 1) : 0);
          c = (cnt > 0) ? ((a >> (N - cnt)) & 1) : 0;
        end else begin
          res = (a >> cnt) | (f ? (mask & ~(mask >> cnt)) : 0);
          c = (cnt > 0) ? ((a >> (cnt - 1)) & 1) : 0;
        end
      end
      default: ;
    endcase
    if (op inside {2, 3, 4, 6}) v = int'(sv > hi || sv < lo);
    if (op <= 9) flg = (((res >> (N - 1)) & 1) << 3) | (int'(res == 0) << 2) | (c << 1) | v;
    else flg = 0;
  endtask

  // driver: issue one op, measure latency, hold DONE for `hold` cycles, release
  task automatic run_op(input int op, input int a, input int b, input int f, input int hold);
    int er, ef, el, lat;
    model(op, a, b, f, er, ef, el);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    alu_ctrl = op[3:0]; alu_a = a[N-1:0]; alu_b = b[N-1:0]; flag_in = f[0];
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    alu_a = N'($urandom); alu_b = N'($urandom); alu_ctrl = 4'($urandom); flag_in = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, el);
    check($sformatf("result op%0d a%0h b%0h f%0d", op, a, b, f), alu_result, er);
    check($sformatf("flags op%0d a%0h b%0h f%0d", op, a, b, f), alu_flags, ef);
    last_res = alu_result;
    last_flg = alu_flags;
    for (int i = 0; i < hold; i++) begin
      alu_a = N'($urandom); alu_b = N'($urandom); alu_ctrl = 4'($urandom);
      flag_in = 1'($urandom); in_valid = 1'b1;
      @(negedge clk);
      check("hold_result", alu_result, er);
      check("hold_flags", alu_flags, ef);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_a = '0; alu_b = '0; flag_in = 1'b0; alu_ctrl = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", alu_result, 0);
    check("rst_flags", alu_flags, 0);

    run_op(2, 4'b0111, 4'b0001, 0, 0);
    check("spec_add_res", last_res, 4'b1000);
    check("spec_add_flg", last_flg, 4'b1001);
    run_op(6, 4'b0011, 4'b0101, 0, 0);
    check("spec_sub_res", last_res, 4'b1110);
    check("spec_sub_flg", last_flg, 4'b1010);
    run_op(8, 4'b1011, 4'b0010, 0, 0);
    check("spec_shl_res", last_res, 4'b1100);
    check("spec_shl_carry", (last_flg >> 1) & 1, 0);
    run_op(9, 4'b1011, 4'b0111, 1, 0);
    check("spec_shr_res", last_res, 4'b1111);
    check("spec_shr_carry", (last_flg >> 1) & 1, 1);
    run_op(3, 4'b0111, 4'b0101, 0, 3);
    run_op(12, 4'b1010, 4'b0101, 1, 0);
    check("spec_illegal_res", last_res, 0);
    check("spec_illegal_flg", last_flg, 0);
    run_op(8, 4'b1001, 4'b0000, 1, 1);
    run_op(4, 4'b1000, 4'b0000, 0, 0);
    run_op(4, 4'b0110, 4'b0000, 1, 0);

    // reset in the middle of a shift discards the operation
    @(negedge clk);
    alu_ctrl = 4'd9; alu_a = 4'b1011; alu_b = 4'd4; flag_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", alu_result, 0);
    check("midrst_flags", alu_flags, 0);
    check("midrst_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_emit", seen, 0);

    for (int i = 0; i < 200; i++) begin
      run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 1), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
